// File: rtl/md_issue_ctrl_if.sv
// E-stage to multiply/divide issue bundle: instruction inputs, unit busy flag,
// issue/stall outputs and latency-monitor observables.
interface md_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      E_Ins;
    logic             E_valid;
    logic             E_flush;
    logic [31:0]      D_Ins;
    logic             md_busy;
    logic             md_start;
    logic [31:0]      md_Ins;
    logic             stall;
    logic [1:0]       state;
    logic [3:0]       busy_cnt;
    logic             lat_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output E_Ins, E_valid, E_flush, D_Ins, md_busy,
        input  md_start, md_Ins, stall, state, busy_cnt, lat_err, stall_cnt
    );

    modport slave (
        input  E_Ins, E_valid, E_flush, D_Ins, md_busy,
        output md_start, md_Ins, stall, state, busy_cnt, lat_err, stall_cnt
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mult/div issue + HI/LO interlock: start, gated instruction and stall are combinational
// (zero latency); the latency monitor and stall counter update on each clk edge.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave io
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    function automatic logic is_mul(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        return ((op == 6'h00) && (fn == 6'h18 || fn == 6'h19)) ||
               ((op == 6'h1C) && (fn == 6'h00 || fn == 6'h01 ||
                                  fn == 6'h04 || fn == 6'h05));
    endfunction

    function automatic logic is_div(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) && (ins[5:0] == 6'h1A || ins[5:0] == 6'h1B);
    endfunction

    function automatic logic is_access(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) && (ins[5:2] == 4'b0100);
    endfunction

    state_e           state_q;
    logic [3:0]       busy_cnt_q;
    logic             lat_err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic   ok;
    logic   start_w;
    logic   stall_w;
    logic   d_hilo;
    state_e new_state;
    logic   [3:0] exp_lat;

    assign ok        = io.E_valid & ~io.E_flush;
    assign start_w   = ok & (is_mul(io.E_Ins) | is_div(io.E_Ins));
    assign d_hilo    = is_mul(io.D_Ins) | is_div(io.D_Ins) | is_access(io.D_Ins);
    // Start cycle must stall too: the unit only raises md_busy on the following cycle.
    assign stall_w   = d_hilo & (start_w | io.md_busy);
    assign new_state = is_div(io.E_Ins) ? S_DIV : S_MUL;
    assign exp_lat   = (state_q == S_DIV) ? DIV_LAT_C : MUL_LAT_C;

    assign io.md_start  = start_w;
    assign io.md_Ins    = ok ? io.E_Ins : 32'h0;
    assign io.stall     = stall_w;
    assign io.state     = state_q;
    assign io.busy_cnt  = busy_cnt_q;
    assign io.lat_err   = lat_err_q;
    assign io.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_cnt_q  <= '0;
            lat_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (stall_w && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_w) begin
                        state_q    <= new_state;
                        busy_cnt_q <= '0;
                    end
                end
                default: begin
                    if (io.md_busy) begin
                        // A new start while the unit is still busy means the interlock was bypassed.
                        if (start_w) begin
                            lat_err_q  <= 1'b1;
                            state_q    <= new_state;
                            busy_cnt_q <= '0;
                        end else if (busy_cnt_q != 4'hF) begin
                            busy_cnt_q <= busy_cnt_q + 4'd1;
                        end
                    end else begin
                        if (busy_cnt_q != exp_lat) begin
                            lat_err_q <= 1'b1;
                        end
                        if (start_w) begin
                            state_q    <= new_state;
                            busy_cnt_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
E-stage issue and interlock controller that sits directly upstream of the multiply/divide unit.
- Decodes the E-stage instruction and drives a single-cycle start pulse plus a gated instruction word into the unit.
- Generates the D-stage stall for every HI/LO-touching instruction while the unit is occupied.
- Runs a latency monitor that checks the unit's busy window against the expected mult/div latency and keeps a saturating stall-cycle counter.

Parameters:
MUL_LAT, 5, expected number of cycles md_busy stays high for mult/multu/madd/maddu/msub/msubu
DIV_LAT, 10, expected number of cycles md_busy stays high for div/divu
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
E_Ins  in  32  instruction in E stage
E_valid  in  1  E-stage instruction is real (not a bubble)
E_flush  in  1  E-stage instruction is being killed this cycle
D_Ins  in  32  instruction in D stage
md_busy  in  1  busy flag from the multiply/divide unit
md_start  out  1  start pulse to the unit (combinational)
md_Ins  out  32  gated instruction to the unit (combinational)
stall  out  1  freeze PC/F/D, bubble into E (combinational)
state  out  2  monitor state: 0 IDLE, 1 MUL_WAIT, 2 DIV_WAIT
busy_cnt  out  4  cycles of md_busy observed in current operation
lat_err  out  1  sticky latency-mismatch flag
stall_cnt  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Decode, with op = Ins[31:26] and func = Ins[5:0]:
  - START_MUL: op 0 with func 0x18/0x19; op 0x1C with func 0x00/0x01/0x04/0x05.
  - START_DIV: op 0 with func 0x1A/0x1B.
  - ACCESS: op 0 with func 0x10/0x11/0x12/0x13 (mfhi/mthi/mflo/mtlo).
  - USES_HILO = START_MUL | START_DIV | ACCESS.
- ok = E_valid & ~E_flush.
- md_start = ok & (START_MUL(E_Ins) | START_DIV(E_Ins)).
- md_Ins = ok ? E_Ins : 32'h0. A flushed or bubble mthi/mtlo must never reach the unit.
- stall = USES_HILO(D_Ins) & (md_start | md_busy).
  - Must cover the start cycle, where md_busy is still 0.
  - No extra cycle once md_busy falls.
- FSM, state changes only on posedge clk:
  - IDLE: on md_start go to MUL_WAIT or DIV_WAIT; busy_cnt <= 0.
  - WAIT with md_busy=1: busy_cnt <= busy_cnt+1, saturating at 15.
  - WAIT with md_busy=0: go to IDLE. If busy_cnt != expected latency (MUL_LAT or DIV_LAT), set lat_err <= 1.
  - md_start while in WAIT (stall contract violated): set lat_err, restart the WAIT state for the new op, busy_cnt <= 0.
- lat_err is cleared only by reset.
- stall_cnt increments every cycle stall=1 and saturates at all-ones.
- Reset (synchronous, any cycle including mid-operation): state=IDLE, busy_cnt=0, lat_err=0, stall_cnt=0. Combinational outputs follow their inputs immediately.
- Simultaneous events:
  - E_flush together with a start op gives md_start=0 and no state change.
  - md_busy falling in the same cycle as a new md_start: IDLE is taken and the new op is entered on the same edge (WAIT→new WAIT), with no lat_err if the count matched.

Test Plan:
- mult $4,$5 (0x00850018) in E with E_valid=1, D=mflo (0x00001012); unit busy for 5 cycles → md_start=1 for 1 cycle; stall=1 for 6 cycles (start + 5 busy); state returns to IDLE; lat_err=0; stall_cnt=6.
- div $4,$5 (0x0085001A), D=add (no HI/LO) → stall stays 0; state goes to DIV_WAIT; busy_cnt reaches 10; lat_err=0.
- mthi $4 (0x00800011) with E_flush=1 → md_Ins=0 and md_start=0; with E_flush=0 → md_Ins=0x00800011 and md_start=0.
- div issued but md_busy forced high for 9 cycles only → IDLE on the 10th cycle and lat_err=1, which stays 1 through later correct ops until reset.
- Reset asserted during cycle 3 of MUL_WAIT → next cycle state=0, busy_cnt=0, stall_cnt=0; stall then tracks md_busy and md_start only.
- md_start with E_valid=0 (bubble carrying 0x00850018) → md_start=0 and md_Ins=0.
